// File: rtl/vector_seq_control_unit.sv
// Vector processor main control: registered opcode decode with a valid/ready
// handshake, stall and flush. SVI/LVI are expanded into LANES/BEAT lane beats.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   instr_valid, opcode   incoming instruction
//   instr_ready           unit can take an opcode this cycle
//   stall_in, flush       downstream stall, synchronous kill
//   ctrl_valid            registered control outputs meaningful
//   ALUControl, RegW, ALUSrc, BranchE, MemW, MemtoReg, regB, vectorMem
//   lane_idx, last_beat   beat position within a vector memory sequence
//   illegal               accepted opcode is not decodable
module vector_seq_control_unit #(
  parameter int LANES = 4,
  parameter int BEAT  = 1,
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  input  logic [4:0]    opcode,
  output logic          instr_ready,
  input  logic          stall_in,
  input  logic          flush,
  output logic          ctrl_valid,
  output logic [3:0]    ALUControl,
  output logic          RegW,
  output logic          ALUSrc,
  output logic          BranchE,
  output logic          MemW,
  output logic          MemtoReg,
  output logic          regB,
  output logic          vectorMem,
  output logic [LW-1:0] lane_idx,
  output logic          last_beat,
  output logic          illegal
);

  localparam int NB = LANES / BEAT;
  localparam bit MULTI = NB > 1;
  localparam logic [LW-1:0] STEP = LW'(BEAT);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - BEAT);

  localparam logic [4:0] OP_SVI = 5'b11101;
  localparam logic [4:0] OP_LVI = 5'b11110;

  typedef enum logic {IDLE, SEQ} state_t;

  typedef struct packed {
    logic [6:0] word;
    logic [3:0] alu;
    logic       ill;
  } dec_t;

  function automatic dec_t decode(input logic [4:0] op);
    dec_t d;
    d = '{word: 7'b0, alu: 4'b0, ill: 1'b0};
    unique case (op)
      5'b00001: begin d.word = 7'b0100000; d.alu = 4'b0000; end
      5'b00010: begin d.word = 7'b0100000; d.alu = 4'b0100; end
      5'b00011: begin d.word = 7'b0100000; d.alu = 4'b0001; end
      5'b00100: begin d.word = 7'b0100000; d.alu = 4'b0010; end
      5'b00101: begin d.word = 7'b0100000; d.alu = 4'b0101; end
      5'b00111: begin d.word = 7'b0100000; d.alu = 4'b0011; end
      5'b01000,
      5'b01001: begin d.word = 7'b0001001; d.alu = 4'b0000; end
      5'b10000: begin d.word = 7'b0110000; d.alu = 4'b0000; end
      5'b10001: begin d.word = 7'b0110000; d.alu = 4'b0110; end
      5'b10010: begin d.word = 7'b0110000; d.alu = 4'b0111; end
      5'b10011: begin d.word = 7'b0010101; d.alu = 4'b0000; end
      5'b10100: begin d.word = 7'b0110011; d.alu = 4'b0000; end
      5'b11000: begin d.word = 7'b0100000; d.alu = 4'b0000; end
      5'b11001: begin d.word = 7'b0100000; d.alu = 4'b0010; end
      5'b11010: begin d.word = 7'b0100000; d.alu = 4'b0101; end
      5'b11011: begin d.word = 7'b0100000; d.alu = 4'b1000; end
      5'b11100: begin d.word = 7'b0100001; d.alu = 4'b1001; end
      5'b11101: begin d.word = 7'b1010101; d.alu = 4'b0000; end
      5'b11110: begin d.word = 7'b1110011; d.alu = 4'b0000; end
      default:  d.ill = 1'b1;
    endcase
    return d;
  endfunction

  state_t        state_q, state_d;
  logic          cv_q, cv_d;
  logic [6:0]    word_q, word_d;
  logic [3:0]    alu_q, alu_d;
  logic [LW-1:0] lane_q, lane_d;
  logic          last_q, last_d;
  logic          ill_q, ill_d;

  dec_t          dec;
  logic          accept;
  logic          vmem_op;
  logic [LW-1:0] lane_nxt;

  assign instr_ready = !stall_in && (state_q == IDLE || last_q);
  assign accept = instr_valid && instr_ready && !flush;
  assign vmem_op = (opcode == OP_SVI) || (opcode == OP_LVI);
  assign lane_nxt = lane_q + STEP;

  always_comb begin
    state_d = state_q;
    cv_d    = cv_q;
    word_d  = word_q;
    alu_d   = alu_q;
    lane_d  = lane_q;
    last_d  = last_q;
    ill_d   = ill_q;
    dec     = decode(opcode);
    if (flush) begin
      state_d = IDLE;
      cv_d    = 1'b0;
      word_d  = '0;
      alu_d   = '0;
      lane_d  = '0;
      last_d  = 1'b0;
      ill_d   = 1'b0;
    end else if (!stall_in) begin
      if (accept) begin
        cv_d   = 1'b1;
        word_d = dec.word;
        alu_d  = dec.alu;
        ill_d  = dec.ill;
        lane_d = '0;
        if (MULTI && vmem_op) begin
          state_d = SEQ;
          last_d  = 1'b0;
        end else begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end else if (state_q == SEQ && !last_q) begin
        // control word is held; only the lane position moves
        lane_d = lane_nxt;
        last_d = (lane_nxt == LAST_LANE);
      end else begin
        state_d = IDLE;
        cv_d    = 1'b0;
        word_d  = '0;
        alu_d   = '0;
        lane_d  = '0;
        last_d  = 1'b0;
        ill_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cv_q    <= 1'b0;
      word_q  <= '0;
      alu_q   <= '0;
      lane_q  <= '0;
      last_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cv_q    <= cv_d;
      word_q  <= word_d;
      alu_q   <= alu_d;
      lane_q  <= lane_d;
      last_q  <= last_d;
      ill_q   <= ill_d;
    end
  end

  assign ctrl_valid = cv_q;
  assign ALUControl = alu_q;
  assign {vectorMem, RegW, ALUSrc, BranchE, MemW, MemtoReg, regB} = word_q;
  assign lane_idx   = lane_q;
  assign last_beat  = last_q;
  assign illegal    = ill_q;

endmodule

// File: tb/tb_vector_seq_control_unit.sv
// Bench for vector_seq_control_unit: three configurations (4/1, 8/2, 4/4)
// driven in lockstep against a beat-counting reference model.
module tb_vector_seq_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       instr_valid;
  logic [4:0] opcode;
  logic       stall_in;
  logic       flush;

  logic [2:0] rdy, cv, rw, as, br, mw, mr, rb, vm, lb, il;
  logic [3:0] alu0, alu1, alu2;
  logic [1:0] l0;
  logic [2:0] l1;
  logic [1:0] l2;

  vector_seq_control_unit #(.LANES(4), .BEAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
    .instr_ready(rdy[0]), .stall_in(stall_in), .flush(flush),
    .ctrl_valid(cv[0]), .ALUControl(alu0), .RegW(rw[0]), .ALUSrc(as[0]),
    .BranchE(br[0]), .MemW(mw[0]), .MemtoReg(mr[0]), .regB(rb[0]),
    .vectorMem(vm[0]), .lane_idx(l0), .last_beat(lb[0]), .illegal(il[0])
  );

  vector_seq_control_unit #(.LANES(8), .BEAT(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
    .instr_ready(rdy[1]), .stall_in(stall_in), .flush(flush),
    .ctrl_valid(cv[1]), .ALUControl(alu1), .RegW(rw[1]), .ALUSrc(as[1]),
    .BranchE(br[1]), .MemW(mw[1]), .MemtoReg(mr[1]), .regB(rb[1]),
    .vectorMem(vm[1]), .lane_idx(l1), .last_beat(lb[1]), .illegal(il[1])
  );

  vector_seq_control_unit #(.LANES(4), .BEAT(4)) dut1b (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
    .instr_ready(rdy[2]), .stall_in(stall_in), .flush(flush),
    .ctrl_valid(cv[2]), .ALUControl(alu2), .RegW(rw[2]), .ALUSrc(as[2]),
    .BranchE(br[2]), .MemW(mw[2]), .MemtoReg(mr[2]), .regB(rb[2]),
    .vectorMem(vm[2]), .lane_idx(l2), .last_beat(lb[2]), .illegal(il[2])
  );

  int tests = 0;
  int fails = 0;

  // {illegal, word[6:0], alu[3:0]}
  logic [11:0] tbl [32];
  int NBV [3] = '{4, 4, 1};
  int BTV [3] = '{1, 2, 4};

  // model: current instruction entry, beat number, beat count
  logic        m_v [3];
  logic [11:0] m_e [3];
  int          m_k [3];
  int          m_n [3];

  typedef struct {
    logic [4:0] op;
    logic [6:0] w;
    logic [3:0] a;
    logic       ill;
  } vec_t;
  vec_t vt [10];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [13:0] act_obs(input int i);
    logic [13:0] r;
    case (i)
      0: r = {cv[0], il[0], lb[0], vm[0], rw[0], as[0], br[0],
              mw[0], mr[0], rb[0], alu0};
      1: r = {cv[1], il[1], lb[1], vm[1], rw[1], as[1], br[1],
              mw[1], mr[1], rb[1], alu1};
      default: r = {cv[2], il[2], lb[2], vm[2], rw[2], as[2], br[2],
                    mw[2], mr[2], rb[2], alu2};
    endcase
    return r;
  endfunction

  function automatic logic [7:0] act_lane(input int i);
    case (i)
      0: return {6'b0, l0};
      1: return {5'b0, l1};
      default: return {6'b0, l2};
    endcase
  endfunction

  function automatic logic [13:0] exp_obs(input int i);
    if (!m_v[i]) return 14'h0;
    return {1'b1, m_e[i][11], m_k[i] == m_n[i] - 1, m_e[i][10:0]};
  endfunction

  function automatic logic [7:0] exp_lane(input int i);
    if (!m_v[i]) return 8'h0;
    return 8'(m_k[i] * BTV[i]);
  endfunction

  function automatic logic exp_rdy(input int i);
    return !stall_in && !(m_v[i] && m_k[i] < m_n[i] - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_v[i] = 1'b0;
      m_e[i] = '0;
      m_k[i] = 0;
      m_n[i] = 1;
    end
  endtask

  task automatic model_step(input int i);
    logic r;
    r = exp_rdy(i);
    if (flush) begin
      m_v[i] = 1'b0;
    end else if (stall_in) begin
      m_v[i] = m_v[i];
    end else if (instr_valid && r) begin
      m_v[i] = 1'b1;
      m_e[i] = tbl[opcode];
      m_k[i] = 0;
      m_n[i] = (opcode == 5'b11101 || opcode == 5'b11110) ? NBV[i] : 1;
    end else if (m_v[i] && m_k[i] < m_n[i] - 1) begin
      m_k[i] = m_k[i] + 1;
    end else begin
      m_v[i] = 1'b0;
    end
  endtask

  task automatic check_outs();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("outs%0d", i), 32'(act_obs(i)), 32'(exp_obs(i)));
      check($sformatf("lane%0d", i), 32'(act_lane(i)), 32'(exp_lane(i)));
    end
  endtask

  // called at a negedge: drive, check ready, clock, check registered outputs
  task automatic step(input logic v, input logic [4:0] op,
                      input logic st, input logic fl);
    instr_valid = v;
    opcode = op;
    stall_in = st;
    flush = fl;
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("ready%0d", i), 32'(rdy[i]), 32'(exp_rdy(i)));
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    @(negedge clk);
    check_outs();
  endtask

  function automatic logic [6:0] word0();
    return {vm[0], rw[0], as[0], br[0], mw[0], mr[0], rb[0]};
  endfunction

  initial begin
    for (int k = 0; k < 32; k++) tbl[k] = 12'h800;
    tbl[5'b00001] = {1'b0, 7'b0100000, 4'b0000};
    tbl[5'b00010] = {1'b0, 7'b0100000, 4'b0100};
    tbl[5'b00011] = {1'b0, 7'b0100000, 4'b0001};
    tbl[5'b00100] = {1'b0, 7'b0100000, 4'b0010};
    tbl[5'b00101] = {1'b0, 7'b0100000, 4'b0101};
    tbl[5'b00111] = {1'b0, 7'b0100000, 4'b0011};
    tbl[5'b01000] = {1'b0, 7'b0001001, 4'b0000};
    tbl[5'b01001] = {1'b0, 7'b0001001, 4'b0000};
    tbl[5'b10000] = {1'b0, 7'b0110000, 4'b0000};
    tbl[5'b10001] = {1'b0, 7'b0110000, 4'b0110};
    tbl[5'b10010] = {1'b0, 7'b0110000, 4'b0111};
    tbl[5'b10011] = {1'b0, 7'b0010101, 4'b0000};
    tbl[5'b10100] = {1'b0, 7'b0110011, 4'b0000};
    tbl[5'b11000] = {1'b0, 7'b0100000, 4'b0000};
    tbl[5'b11001] = {1'b0, 7'b0100000, 4'b0010};
    tbl[5'b11010] = {1'b0, 7'b0100000, 4'b0101};
    tbl[5'b11011] = {1'b0, 7'b0100000, 4'b1000};
    tbl[5'b11100] = {1'b0, 7'b0100001, 4'b1001};
    tbl[5'b11101] = {1'b0, 7'b1010101, 4'b0000};
    tbl[5'b11110] = {1'b0, 7'b1110011, 4'b0000};

    vt[0] = '{5'b00001, 7'b0100000, 4'b0000, 1'b0};
    vt[1] = '{5'b00010, 7'b0100000, 4'b0100, 1'b0};
    vt[2] = '{5'b00111, 7'b0100000, 4'b0011, 1'b0};
    vt[3] = '{5'b01001, 7'b0001001, 4'b0000, 1'b0};
    vt[4] = '{5'b10001, 7'b0110000, 4'b0110, 1'b0};
    vt[5] = '{5'b10011, 7'b0010101, 4'b0000, 1'b0};
    vt[6] = '{5'b10100, 7'b0110011, 4'b0000, 1'b0};
    vt[7] = '{5'b11011, 7'b0100000, 4'b1000, 1'b0};
    vt[8] = '{5'b11100, 7'b0100001, 4'b1001, 1'b0};
    vt[9] = '{5'b00110, 7'b0000000, 4'b0000, 1'b1};

    model_reset();
    rst_n = 1'b0;
    instr_valid = 1'b0;
    opcode = '0;
    stall_in = 1'b0;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    check_outs();
    rst_n = 1'b1;

    // single-beat decode table, each followed by a bubble
    for (int j = 0; j < 10; j++) begin
      step(1'b1, vt[j].op, 1'b0, 1'b0);
      check("tbl_valid", 32'(cv[0]), 32'd1);
      check("tbl_word", 32'(word0()), 32'(vt[j].w));
      check("tbl_alu", 32'(alu0), 32'(vt[j].a));
      check("tbl_ill", 32'(il[0]), 32'(vt[j].ill));
      check("tbl_last", 32'(lb[0]), 32'd1);
      step(1'b0, 5'b0, 1'b0, 1'b0);
      check("bubble", 32'(cv[0]), 32'd0);
    end

    // LVI on 4 lanes, MULV issued on the final beat
    step(1'b1, 5'b11110, 1'b0, 1'b0);
    check("lvi_word", 32'(word0()), 32'h73);
    check("lvi_lane0", 32'(l0), 32'd0);
    check("lvi_last0", 32'(lb[0]), 32'd0);
    for (int j = 1; j < 4; j++) begin
      check("lvi_busy", 32'(rdy[0]), 32'd0);
      step(1'b0, 5'b0, 1'b0, 1'b0);
      check("lvi_lane", 32'(l0), 32'(j));
      check("lvi_hold", 32'(word0()), 32'h73);
    end
    check("lvi_last3", 32'(lb[0]), 32'd1);
    step(1'b1, 5'b11001, 1'b0, 1'b0);
    check("mulv_alu", 32'(alu0), 32'h2);
    check("mulv_valid", 32'(cv[0]), 32'd1);
    step(1'b0, 5'b0, 1'b0, 1'b0);

    // SVI on 8 lanes / 2 per beat
    step(1'b1, 5'b11101, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++) begin
      if (j > 0) step(1'b0, 5'b0, 1'b0, 1'b0);
      check("svi8_lane", 32'(l1), 32'(2 * j));
      check("svi8_mem", 32'({mw[1], vm[1]}), 32'h3);
      check("svi8_last", 32'(lb[1]), 32'(j == 3));
    end
    step(1'b0, 5'b0, 1'b0, 1'b0);

    // SVI with a 3-cycle stall at lane 1
    step(1'b1, 5'b11101, 1'b0, 1'b0);
    step(1'b0, 5'b0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      step(1'b1, 5'b00001, 1'b1, 1'b0);
      check("stall_lane", 32'(l0), 32'd1);
      check("stall_rdy", 32'(rdy[0]), 32'd0);
    end
    step(1'b0, 5'b0, 1'b0, 1'b0);
    check("resume_lane", 32'(l0), 32'd2);
    step(1'b0, 5'b0, 1'b0, 1'b0);
    step(1'b0, 5'b0, 1'b0, 1'b0);
    step(1'b0, 5'b0, 1'b0, 1'b0);

    // flush at lane 2 of LVI, while stalled with an opcode valid
    step(1'b1, 5'b11110, 1'b0, 1'b0);
    step(1'b0, 5'b0, 1'b0, 1'b0);
    step(1'b0, 5'b0, 1'b0, 1'b0);
    check("pre_flush_lane", 32'(l0), 32'd2);
    step(1'b1, 5'b00001, 1'b1, 1'b1);
    check("flush_outs", 32'(act_obs(0)), 32'd0);
    check("flush_lane", 32'(l0), 32'd0);
    step(1'b0, 5'b0, 1'b0, 1'b0);
    check("flush_drop", 32'(cv[0]), 32'd0);

    // asynchronous reset mid-sequence
    step(1'b1, 5'b11110, 1'b0, 1'b0);
    step(1'b0, 5'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("arst_outs%0d", i), 32'(act_obs(i)), 32'd0);
      check($sformatf("arst_lane%0d", i), 32'(act_lane(i)), 32'd0);
    end
    model_reset();
    #2;
    rst_n = 1'b1;

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 1) == 0) ?
           (($urandom_range(0, 1) == 0) ? 5'b11101 : 5'b11110) :
           5'($urandom);
      step($urandom_range(0, 3) != 0, op,
           $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vector_seq_control_unit.md
Name: vector_seq_control_unit

Overview:
Registered, handshaked main control unit for the vector processor. It decodes a 5-bit opcode into the scalar/vector control word and ALU selector. Vector memory instructions (SVI, LVI) are expanded into multi-beat lane sequences, which lets the datapath scale to LANES elements with a narrower memory port. It sits between fetch/decode and the execute stage and replaces the purely combinational decode with a 1-cycle-latency pipelined unit that supports stall and flush.

Parameters:
LANES, 4, vector elements per register; power of two, 1 or more
BEAT, 1, lanes transferred per memory beat; power of two; LANES % BEAT == 0
LW, max(1,$clog2(LANES)), width of lane_idx (localparam)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  opcode is valid this cycle
opcode  in  5  instruction opcode
instr_ready  out  1  unit accepts opcode this cycle (combinational)
stall_in  in  1  downstream stall; freeze all registered outputs
flush  in  1  synchronous kill of the current and in-flight instruction
ctrl_valid  out  1  control outputs are meaningful this cycle
ALUControl  out  4  ALU operation select
RegW, ALUSrc, BranchE, MemW, MemtoReg, regB, vectorMem  out  1 each  datapath controls
lane_idx  out  LW  first lane of the current beat
last_beat  out  1  final (or only) beat of the instruction
illegal  out  1  accepted opcode is not in the decode table

Behaviour:
- Control word order is {vectorMem,RegW,ALUSrc,BranchE,MemW,MemtoReg,regB}. Decode table (opcode: word, ALUControl):
  ADD 00001: 0100000, 0000; AND 00010: 0100000, 0100; SUB 00011: 0100000, 0001; MUL 00100: 0100000, 0010
  DIV 00101: 0100000, 0101; MOD 00111: 0100000, 0011; BEQ 01000 and BGT 01001: 0001001, 0000
  ADDI 10000: 0110000, 0000; SRL 10001: 0110000, 0110; SLL 10010: 0110000, 0111
  SB 10011: 0010101, 0000; LB 10100: 0110011, 0000
  ADDV 11000: 0100000, 0000; MULV 11001: 0100000, 0010; DIVV 11010: 0100000, 0101; REP 11011: 0100000, 1000
  MOVV 11100: 0100001, 1001; SVI 11101: 1010101, 0000; LVI 11110: 1110011, 0000
  Any other opcode: word 0000000, ALUControl 0000, illegal=1.
- Reset (rst_n low, asynchronous): state IDLE. ctrl_valid, all control bits, ALUControl, lane_idx, last_beat and illegal are all 0. Reset mid-sequence abandons the sequence.
- Handshake: instr_ready = !stall_in && (state==IDLE || last_beat). An opcode is accepted on a rising edge when instr_valid && instr_ready && !flush.
- Latency: the decoded outputs appear the cycle after acceptance with ctrl_valid=1, lane_idx=0.
- Non-SVI/LVI opcode, or SVI/LVI when NB = LANES/BEAT == 1: single beat, last_beat=1, state stays IDLE.
- SVI/LVI with NB > 1: state SEQ. The control word is held for NB cycles and lane_idx steps 0, BEAT, 2*BEAT, ... (LANES-BEAT). last_beat=1 only on the final beat. instr_ready=0 on all other beats of the sequence.
- Back-to-back issue: during a final beat with stall_in=0, a new opcode may be accepted, so the next instruction follows with no bubble. When no opcode is accepted, the next cycle is a bubble: ctrl_valid=0 and all control outputs 0.
- stall_in=1: every output and the state hold. lane_idx does not advance and nothing is accepted.
- flush=1: highest priority, over stall_in and acceptance. Next cycle: state IDLE, ctrl_valid=0, all outputs 0. An opcode presented in the flush cycle is not accepted.
- An illegal opcode occupies exactly one beat, with ctrl_valid=1 and illegal=1.

Test Plan:
- Reset, then ADD(00001) valid with stall_in=0 -> next cycle ctrl_valid=1, RegW=1, ALUControl=0000, last_beat=1; following cycle ctrl_valid=0.
- LANES=4, BEAT=1, LVI(11110) -> 4 cycles of control word 1110011 with lane_idx 0,1,2,3; last_beat only at lane 3; instr_ready=0 for cycles 1-3; MULV presented on the last beat is accepted and appears next cycle with ALUControl=0010.
- LANES=8, BEAT=2, SVI(11101) -> lane_idx 0,2,4,6; MemW=1, vectorMem=1 on all 4 beats.
- SVI sequence with stall_in=1 for 3 cycles at lane 1 -> outputs frozen at lane_idx=1, instr_ready=0; the sequence resumes at lane 2 with no lane skipped or repeated.
- flush asserted at lane 2 of LVI while stall_in=1 and an opcode is valid -> next cycle ctrl_valid=0 and all outputs 0, state IDLE, the presented opcode is dropped.
- Opcode 00110 -> ctrl_valid=1, illegal=1, control word 0 for one beat. rst_n pulsed low mid-sequence -> outputs 0 immediately, without waiting for a clock edge.
